control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clock  input  1  single system clock, all state rising-edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: opcode  input  7  instruction[6:0] from instruction register.
REQ-004 SHALL have: branch_taken  input  1  comparator result for current Branch.
REQ-005 SHALL have: memory_ready  input  1  memory completes current request this cycle.
REQ-006 SHALL have: memory_request  output  1  memory access valid.
REQ-007 SHALL have: memory_write  output  1  access is a store; only meaningful with memory_request.
REQ-008 SHALL have: memory_address_select  output  1  0 = PC, 1 = ALU result.
REQ-009 SHALL have: instruction_register_enable  output  1  latch fetched word.
REQ-010 SHALL have: alu_source_a / alu_source_b  output  1 each  a: 0 = rs1, 1 = PC; b: 0 = rs2, 1 = immediate.
REQ-011 SHALL have: pc_write  output  1; pc_source  output  2  0 = PC+4, 1 = PC+imm, 2 = ALU result.
REQ-012 SHALL have: register_write  output  1; writeback_select  output  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate.
REQ-013 SHALL have: halted  output  1; illegal_instruction  output  1 (sticky); retired_count  output  32.

Function
REQ-014 SHALL be a Moore FSM, states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT; all outputs are functions of state, opcode and branch_taken only.
REQ-015 FETCH: memory_request=1, address_select=0; held until memory_ready sampled high; that cycle instruction_register_enable=1, next DECODE; minimum 1 cycle (zero-wait memory allowed).
REQ-016 DECODE: 1 cycle; Load, Store, Branch, Immediate_Arithmetic, Register_Arithmetic, JAL, JALR, LUI, AUIPC, Fence -> EXECUTE; System (1110011) -> HALT, illegal=0; any other opcode -> HALT, illegal=1.
REQ-017 EXECUTE: 1 cycle; alu_source_a=1 for AUIPC/JAL/Branch, alu_source_b=1 for all except Register_Arithmetic and Branch.
REQ-018 EXECUTE Branch: pc_write=1, pc_source=1 if branch_taken else 0, next FETCH; Fence: pc_write=1, pc_source=0, next FETCH.
REQ-019 EXECUTE Load/Store -> MEMORY; all others -> WRITEBACK.
REQ-020 MEMORY: memory_request=1, address_select=1, memory_write=1 iff Store; held until memory_ready; then Load -> WRITEBACK, Store -> pc_write=1, pc_source=0, FETCH.
REQ-021 WRITEBACK: 1 cycle, register_write=1, pc_write=1; writeback_select: Load 1, JAL/JALR 2, LUI 3, else 0; pc_source: JAL 1, JALR 2, else 0; next FETCH.
REQ-022 memory_request SHALL deassert the cycle after memory_ready accepted; memory_ready while memory_request=0 SHALL be ignored.
REQ-023 pc_write SHALL be asserted exactly one cycle per retired instruction; retired_count increments on each pc_write, wraps 0xFFFFFFFF -> 0.
REQ-024 HALT is terminal: all strobes 0, halted=1; exit only via reset.
REQ-025 Outputs not listed for a state SHALL be 0.

Reset
REQ-026 reset SHALL asynchronously force state FETCH-pending-release, retired_count=0, illegal_instruction=0, halted=0, all strobes 0, including mid-memory-access (request dropped same cycle).
REQ-027 After reset release, first rising edge SHALL enter/remain FETCH with memory_request=1.

Structure
REQ-028 State enum and pc_source/writeback_select encodings SHALL live in the shared package alongside opcode_t.
REQ-029 Opcode classification (legal, uses immediate, needs memory, writes register) SHALL be one combinational sub-module, instruction_decoder.

Verification
REQ-030 ADDI (0x00500093), zero-wait memory -> FETCH,DECODE,EXECUTE,WRITEBACK; register_write=1, writeback_select=0, retired_count 0->1 in 4 cycles.
REQ-031 LW with memory_ready delayed 3 cycles in FETCH and MEMORY -> memory_request held 4 cycles each, memory_write=0, writeback_select=1, 8 cycles total.
REQ-032 BEQ with branch_taken=1 then =0 -> pc_source 1 then 0, no register_write, 3 cycles each.
REQ-033 Opcode 0x7F -> HALT, illegal_instruction=1, halted=1, no pc_write; ECALL -> halted=1, illegal=0.
REQ-034 reset asserted mid-MEMORY of SW -> memory_request/memory_write drop without clock edge, retired_count=0, FETCH after release.
REQ-035 retired_count preloaded (force) to 0xFFFFFFFF, one JAL -> count 0, writeback_select=2, pc_source=1.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types for the multi-cycle control unit:
// opcodes, FSM states and PC / writeback mux encodings.
package control_unit_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational opcode classifier.
// In: opcode. Out: legal, system, uses_immediate, needs_memory, writes_register.
module instruction_decoder
  import control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       system,
  output logic       uses_immediate,
  output logic       needs_memory,
  output logic       writes_register
);

  always_comb begin
    legal           = 1'b1;
    system          = 1'b0;
    uses_immediate  = 1'b1;
    needs_memory    = 1'b0;
    writes_register = 1'b0;
    case (opcode)
      OP_LOAD: begin
        needs_memory    = 1'b1;
        writes_register = 1'b1;
      end
      OP_STORE:  needs_memory = 1'b1;
      OP_BRANCH: uses_immediate = 1'b0;
      OP_REG: begin
        uses_immediate  = 1'b0;
        writes_register = 1'b1;
      end
      OP_IMM, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC: writes_register = 1'b1;
      OP_FENCE:  ;
      OP_SYSTEM: system = 1'b1;
      default: begin
        legal          = 1'b0;
        uses_immediate = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM with retire counter.
// In: clock, reset, opcode, branch_taken, memory_ready. Out: datapath strobes,
// mux selects, halted, illegal_instruction, retired_count.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        memory_ready,
  output logic        memory_request,
  output logic        memory_write,
  output logic        memory_address_select,
  output logic        instruction_register_enable,
  output logic        alu_source_a,
  output logic        alu_source_b,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        register_write,
  output logic [1:0]  writeback_select,
  output logic        halted,
  output logic        illegal_instruction,
  output logic [31:0] retired_count
);

  state_t state;

  logic legal, system, uses_immediate;
  logic needs_memory, writes_register;

  instruction_decoder u_decoder (
    .opcode          (opcode),
    .legal           (legal),
    .system          (system),
    .uses_immediate  (uses_immediate),
    .needs_memory    (needs_memory),
    .writes_register (writes_register)
  );

  logic is_load, is_store, is_branch, is_fence;
  logic is_jal, is_jalr, is_lui, is_auipc;

  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_fence  = opcode == OP_FENCE;
  assign is_jal    = opcode == OP_JAL;
  assign is_jalr   = opcode == OP_JALR;
  assign is_lui    = opcode == OP_LUI;
  assign is_auipc  = opcode == OP_AUIPC;

  assign halted = (state == S_HALT) && !reset;

  // Strobes decode from state so an async reset drops them at once.
  // The two handshake-completion strobes are qualified by memory_ready
  // so each fetch latches once and a store retires in exactly one cycle.
  always_comb begin
    memory_request              = 1'b0;
    memory_write                = 1'b0;
    memory_address_select       = 1'b0;
    instruction_register_enable = 1'b0;
    alu_source_a                = 1'b0;
    alu_source_b                = 1'b0;
    pc_write                    = 1'b0;
    pc_source                   = PC_PLUS4;
    register_write              = 1'b0;
    writeback_select            = WB_ALU;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          memory_request              = 1'b1;
          instruction_register_enable = memory_ready;
        end
        S_EXECUTE: begin
          alu_source_a = is_auipc | is_jal | is_branch;
          alu_source_b = uses_immediate;
          if (is_branch) begin
            pc_write  = 1'b1;
            pc_source = branch_taken ? PC_IMM : PC_PLUS4;
          end
          if (is_fence) pc_write = 1'b1;
        end
        S_MEMORY: begin
          memory_request        = 1'b1;
          memory_address_select = 1'b1;
          memory_write          = is_store;
          pc_write              = is_store & memory_ready;
        end
        S_WRITEBACK: begin
          register_write = 1'b1;
          pc_write       = 1'b1;
          if (is_load)
            writeback_select = WB_MEM;
          else if (is_jal | is_jalr)
            writeback_select = WB_PC4;
          else if (is_lui)
            writeback_select = WB_IMM;
          if (is_jal)
            pc_source = PC_IMM;
          else if (is_jalr)
            pc_source = PC_ALU;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= S_FETCH;
      illegal_instruction <= 1'b0;
      retired_count       <= '0;
    end else begin
      if (pc_write)
        retired_count <= retired_count + 32'd1;
      unique case (state)
        S_FETCH:
          if (memory_ready) state <= S_DECODE;
        S_DECODE:
          if (!legal) begin
            state               <= S_HALT;
            illegal_instruction <= 1'b1;
          end else if (system)
            state <= S_HALT;
          else
            state <= S_EXECUTE;
        S_EXECUTE:
          if (needs_memory)
            state <= S_MEMORY;
          else if (writes_register)
            state <= S_WRITEBACK;
          else
            state <= S_FETCH;
        S_MEMORY:
          if (memory_ready)
            state <= is_store ? S_FETCH : S_WRITEBACK;
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instructions,
// retire records checked by an independent pc_write monitor.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        branch_taken = 1'b0;
  logic        memory_ready = 1'b0;
  logic        memory_request, memory_write, memory_address_select;
  logic        instruction_register_enable;
  logic        alu_source_a, alu_source_b, pc_write, register_write;
  logic [1:0]  pc_source, writeback_select;
  logic        halted, illegal_instruction;
  logic [31:0] retired_count;

  control_unit dut (
    .clock                       (clock),
    .reset                       (reset),
    .opcode                      (opcode),
    .branch_taken                (branch_taken),
    .memory_ready                (memory_ready),
    .memory_request              (memory_request),
    .memory_write                (memory_write),
    .memory_address_select       (memory_address_select),
    .instruction_register_enable (instruction_register_enable),
    .alu_source_a                (alu_source_a),
    .alu_source_b                (alu_source_b),
    .pc_write                    (pc_write),
    .pc_source                   (pc_source),
    .register_write              (register_write),
    .writeback_select            (writeback_select),
    .halted                      (halted),
    .illegal_instruction         (illegal_instruction),
    .retired_count               (retired_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  pcs;
    logic        rw;
    logic [1:0]  wbs;
    logic [31:0] cnt;
  } ret_t;

  ret_t        sb[$];
  logic [31:0] exp_count = 32'd0;

  int n_cyc, n_req, n_wr, n_rw, n_ir, n_a, n_b, n_asel;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Retire monitor: every pc_write must match the oldest queued record.
  always @(negedge clock) begin
    if (pc_write) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", {31'd0, pc_write}, 32'd0);
      end else begin
        ret_t e;
        e = sb.pop_front();
        check("ret_pc_source", {30'd0, pc_source}, {30'd0, e.pcs});
        check("ret_reg_write", {31'd0, register_write}, {31'd0, e.rw});
        check("ret_wb_select", {30'd0, writeback_select}, {30'd0, e.wbs});
        check("ret_count", retired_count, e.cnt);
      end
    end
  end

  task automatic expect_retire(input logic [1:0] pcs, input logic rw,
                               input logic [1:0] wbs);
    ret_t e;
    e.pcs = pcs;
    e.rw  = rw;
    e.wbs = wbs;
    e.cnt = exp_count;
    sb.push_back(e);
    exp_count = exp_count + 32'd1;
  endtask

  task automatic clr();
    n_cyc = 0; n_req = 0; n_wr = 0; n_rw = 0;
    n_ir = 0; n_a = 0; n_b = 0; n_asel = 0;
  endtask

  // One clock: drive ready, sample at negedge, return at posedge+1.
  task automatic cyc(input logic rdy);
    memory_ready = rdy;
    @(negedge clock);
    n_cyc++;
    n_req  += int'(memory_request);
    n_wr   += int'(memory_write);
    n_rw   += int'(register_write);
    n_ir   += int'(instruction_register_enable);
    n_a    += int'(alu_source_a);
    n_b    += int'(alu_source_b);
    n_asel += int'(memory_address_select);
    @(posedge clock);
    #1;
  endtask

  function automatic logic goes_halt(input logic [6:0] op);
    return !(op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG,
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE});
  endfunction

  task automatic run(input logic [6:0] op, input int fw, input int mw,
                     input logic tk);
    clr();
    opcode = op;
    branch_taken = tk;
    for (int i = 0; i <= fw; i++) cyc(i == fw);
    cyc(1'b0);
    if (!goes_halt(op)) begin
      cyc(1'b0);
      if (op == OP_LOAD || op == OP_STORE)
        for (int i = 0; i <= mw; i++) cyc(i == mw);
      if (!(op inside {OP_BRANCH, OP_FENCE, OP_STORE}))
        cyc(1'b0);
    end
    memory_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clock);
    check("rst_mem_req", {31'd0, memory_request}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal_instruction}, 32'd0);
    check("rst_count", retired_count, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // First cycle after release: FETCH with request up
    clr();
    cyc(1'b0);
    check("post_rst_req", n_req, 1);
    check("post_rst_ir_en", n_ir, 0);

    // ADDI x1,x0,5 zero-wait
    expect_retire(PC_PLUS4, 1'b1, WB_ALU);
    run(7'h13, 0, 0, 1'b0);
    check("addi_cycles", n_cyc, 4);
    check("addi_req", n_req, 1);
    check("addi_ir_en", n_ir, 1);
    check("addi_alu_b", n_b, 1);
    check("addi_count", retired_count, 32'd1);

    // LW with 3 wait cycles in fetch and memory
    expect_retire(PC_PLUS4, 1'b1, WB_MEM);
    run(OP_LOAD, 3, 3, 1'b0);
    check("lw_req_cycles", n_req, 8);
    check("lw_mem_write", n_wr, 0);
    check("lw_addr_sel", n_asel, 4);
    check("lw_ir_en", n_ir, 1);

    // BEQ taken, then not taken
    expect_retire(PC_IMM, 1'b0, WB_ALU);
    run(OP_BRANCH, 0, 0, 1'b1);
    check("beq_t_cycles", n_cyc, 3);
    check("beq_t_reg_write", n_rw, 0);
    check("beq_alu_a", n_a, 1);
    check("beq_alu_b", n_b, 0);
    expect_retire(PC_PLUS4, 1'b0, WB_ALU);
    run(OP_BRANCH, 0, 0, 1'b0);
    check("beq_n_cycles", n_cyc, 3);

    // SW with one memory wait cycle
    expect_retire(PC_PLUS4, 1'b0, WB_ALU);
    run(OP_STORE, 0, 1, 1'b0);
    check("sw_cycles", n_cyc, 5);
    check("sw_mem_write", n_wr, 2);
    check("sw_reg_write", n_rw, 0);

    // JALR, LUI, AUIPC, R-type, FENCE
    expect_retire(PC_ALU, 1'b1, WB_PC4);
    run(OP_JALR, 0, 0, 1'b0);
    check("jalr_cycles", n_cyc, 4);
    expect_retire(PC_PLUS4, 1'b1, WB_IMM);
    run(OP_LUI, 0, 0, 1'b0);
    expect_retire(PC_PLUS4, 1'b1, WB_ALU);
    run(OP_AUIPC, 0, 0, 1'b0);
    check("auipc_alu_a", n_a, 1);
    check("auipc_alu_b", n_b, 1);
    expect_retire(PC_PLUS4, 1'b1, WB_ALU);
    run(OP_REG, 1, 0, 1'b0);
    check("add_alu_a", n_a, 0);
    check("add_alu_b", n_b, 0);
    check("add_cycles", n_cyc, 5);
    expect_retire(PC_PLUS4, 1'b0, WB_ALU);
    run(OP_FENCE, 0, 0, 1'b0);
    check("fence_cycles", n_cyc, 3);
    check("fence_reg_write", n_rw, 0);
    check("count_after_mix", retired_count, exp_count);

    // Counter wrap on a JAL
    force dut.retired_count = 32'hFFFF_FFFF;
    #1 release dut.retired_count;
    exp_count = 32'hFFFF_FFFF;
    expect_retire(PC_IMM, 1'b1, WB_PC4);
    run(OP_JAL, 0, 0, 1'b0);
    check("jal_wrap_count", retired_count, 32'd0);

    // Reset in the middle of a stalled SW memory access
    clr();
    opcode = OP_STORE;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    memory_ready = 1'b0;
    @(negedge clock);
    check("sw_mid_req", {31'd0, memory_request}, 32'd1);
    check("sw_mid_write", {31'd0, memory_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", {31'd0, memory_request}, 32'd0);
    check("async_rst_write", {31'd0, memory_write}, 32'd0);
    check("async_rst_count", retired_count, 32'd0);
    exp_count = 32'd0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rel_fetch_req", {31'd0, memory_request}, 32'd1);
    check("rel_fetch_write", {31'd0, memory_write}, 32'd0);
    @(posedge clock);
    #1;

    // Illegal opcode halts and ignores memory_ready afterwards
    run(7'h7F, 0, 0, 1'b0);
    clr();
    for (int i = 0; i < 4; i++) cyc(1'b1);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_flag", {31'd0, illegal_instruction}, 32'd1);
    check("ill_no_req", n_req, 0);
    check("ill_count", retired_count, 32'd0);

    // Reset clears sticky flag; ECALL halts cleanly
    reset = 1'b1;
    #3;
    check("rst_clr_illegal", {31'd0, illegal_instruction}, 32'd0);
    check("rst_clr_halted", {31'd0, halted}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    run(7'h73, 0, 0, 1'b0);
    check("ecall_halted", {31'd0, halted}, 32'd1);
    check("ecall_illegal", {31'd0, illegal_instruction}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
